// File: rtl/demux_1_to_n_stream.sv
// Registered 1-to-NCH valid/ready stream demultiplexer with packet-locked routing,
// per-channel backpressured output slots and drop reporting for unmapped selects.
module demux_1_to_n_stream #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [NCH*WIDTH-1:0]   out_data,
    output logic [NCH-1:0]         out_last,
    output logic [NCH-1:0]         out_valid,
    input  logic [NCH-1:0]         out_ready,
    output logic                   err,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int NSEL = 2 ** SEL_W;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     lock_sel_q, lock_sel_d;
    logic [NCH*WIDTH-1:0] out_data_q, out_data_d;
    logic [NCH-1:0]       out_last_q, out_last_d;
    logic [NCH-1:0]       out_valid_q, out_valid_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

    logic [SEL_W-1:0]     route_sel;
    logic                 route_ok;
    logic [NSEL-1:0]      slot_free;
    logic                 xfer;
    logic [NCH-1:0]       load;

    // Unmapped select codes read as always-free slots, which makes the drop path never stall.
    always_comb begin
        slot_free = '1;
        for (int c = 0; c < NCH; c++) begin
            slot_free[c] = !out_valid_q[c] || out_ready[c];
        end
    end

    assign route_sel = (state_q == LOCKED) ? lock_sel_q : in_sel;
    assign route_ok  = {1'b0, route_sel} < (SEL_W + 1)'(NCH);
    assign in_ready  = slot_free[route_sel];
    assign xfer      = in_valid && in_ready;

    always_comb begin
        load        = '0;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        for (int c = 0; c < NCH; c++) begin
            load[c] = xfer && route_ok && (route_sel == SEL_W'(c));
            // A load in the same cycle as a drain keeps the slot valid.
            out_valid_d[c] = load[c] || (out_valid_q[c] && !out_ready[c]);
            if (load[c]) begin
                out_data_d[c*WIDTH +: WIDTH] = in_data;
                out_last_d[c]                = in_last;
            end
        end
    end

    always_comb begin
        err_d      = xfer && !route_ok;
        drop_cnt_d = drop_cnt_q;
        if (err_d && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        if (xfer) begin
            case (state_q)
                IDLE: begin
                    if (!in_last) begin
                        state_d    = LOCKED;
                        lock_sel_d = in_sel;
                    end
                end
                LOCKED: begin
                    if (in_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_sel_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= '0;
            out_valid_q <= '0;
            err_q       <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lock_sel_q  <= lock_sel_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_1_to_n_stream.sv
// Directed table-driven bench for demux_1_to_n_stream: a 4-channel instance for routing,
// locking, backpressure and reset, plus a 3-channel, 2-bit-counter instance for drops.
module tb_demux_1_to_n_stream;

    logic        clk = 1'b0;
    logic        rst;

    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_last, in_valid, in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_last, out_valid, out_ready;
    logic        err;
    logic [7:0]  drop_cnt;

    logic [7:0]  d3_data;
    logic [1:0]  d3_sel;
    logic        d3_last, d3_valid, d3_ready;
    logic [23:0] d3_out_data;
    logic [2:0]  d3_out_last, d3_out_valid, d3_out_ready;
    logic        d3_err;
    logic [1:0]  d3_drop_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_1_to_n_stream #(.WIDTH(8), .NCH(4), .SEL_W(2), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .err(err), .drop_cnt(drop_cnt)
    );

    demux_1_to_n_stream #(.WIDTH(8), .NCH(3), .SEL_W(2), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_data(d3_data), .in_sel(d3_sel), .in_last(d3_last),
        .in_valid(d3_valid), .in_ready(d3_ready),
        .out_data(d3_out_data), .out_last(d3_out_last), .out_valid(d3_out_valid),
        .out_ready(d3_out_ready), .err(d3_err), .drop_cnt(d3_drop_cnt)
    );

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] d;
        logic       l;
        logic [3:0] rdy;
        logic       irdy;
        logic [3:0] ov;
        logic [3:0] ol;
        logic [31:0] od;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'd0, 8'hA0, 1'b1, 4'hF, 1'b1, 4'h1, 4'h1, 32'h000000A0};
        vecs[1]  = '{1'b1, 2'd1, 8'hA1, 1'b1, 4'hF, 1'b1, 4'h2, 4'h3, 32'h0000A1A0};
        vecs[2]  = '{1'b1, 2'd2, 8'hA2, 1'b1, 4'hF, 1'b1, 4'h4, 4'h7, 32'h00A2A1A0};
        vecs[3]  = '{1'b1, 2'd3, 8'hA3, 1'b1, 4'hF, 1'b1, 4'h8, 4'hF, 32'hA3A2A1A0};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'h0, 4'hF, 32'hA3A2A1A0};
        vecs[5]  = '{1'b1, 2'd2, 8'h11, 1'b0, 4'hF, 1'b1, 4'h4, 4'hB, 32'hA311A1A0};
        vecs[6]  = '{1'b1, 2'd1, 8'h22, 1'b0, 4'hF, 1'b1, 4'h4, 4'hB, 32'hA322A1A0};
        vecs[7]  = '{1'b1, 2'd1, 8'h33, 1'b1, 4'hF, 1'b1, 4'h4, 4'hF, 32'hA333A1A0};
        vecs[8]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'h0, 4'hF, 32'hA333A1A0};
        vecs[9]  = '{1'b1, 2'd1, 8'hB1, 1'b1, 4'hD, 1'b1, 4'h2, 4'hF, 32'hA333B1A0};
        vecs[10] = '{1'b1, 2'd1, 8'hB2, 1'b1, 4'hD, 1'b0, 4'h2, 4'hF, 32'hA333B1A0};
        vecs[11] = '{1'b1, 2'd1, 8'hB2, 1'b1, 4'hF, 1'b1, 4'h2, 4'hF, 32'hA333B2A0};
        vecs[12] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'h0, 4'hF, 32'hA333B2A0};
        vecs[13] = '{1'b1, 2'd0, 8'hC0, 1'b1, 4'hE, 1'b1, 4'h1, 4'hF, 32'hA333B2C0};
        vecs[14] = '{1'b1, 2'd3, 8'hC3, 1'b1, 4'hE, 1'b1, 4'h9, 4'hF, 32'hC333B2C0};
        vecs[15] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hE, 1'b0, 4'h1, 4'hF, 32'hC333B2C0};
        vecs[16] = '{1'b1, 2'd0, 8'hC1, 1'b1, 4'hE, 1'b0, 4'h1, 4'hF, 32'hC333B2C0};
        vecs[17] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'h0, 4'hF, 32'hC333B2C0};

        rst = 1'b1;
        in_data = '0; in_sel = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 4'hF;
        d3_data = '0; d3_sel = '0; d3_last = 1'b0; d3_valid = 1'b0; d3_out_ready = 3'h7;
        edge_wait();
        edge_wait();

        chk("rst_out_valid", out_valid, 4'h0);
        chk("rst_out_data",  out_data,  32'h0);
        chk("rst_out_last",  out_last,  4'h0);
        chk("rst_err",       err,       1'b0);
        chk("rst_drop_cnt",  drop_cnt,  8'h0);
        chk("rst_d3_drop",   d3_drop_cnt, 2'h0);
        rst = 1'b0;
        edge_wait();

        for (int i = 0; i < 18; i++) begin
            in_valid = vecs[i].v; in_sel = vecs[i].sel; in_data = vecs[i].d;
            in_last = vecs[i].l; out_ready = vecs[i].rdy;
            #1;
            chk($sformatf("row%0d_in_ready", i), in_ready, vecs[i].irdy);
            edge_wait();
            chk($sformatf("row%0d_out_valid", i), out_valid, vecs[i].ov);
            chk($sformatf("row%0d_out_last", i),  out_last,  vecs[i].ol);
            chk($sformatf("row%0d_out_data", i),  out_data,  vecs[i].od);
            chk($sformatf("row%0d_err", i),       err,       1'b0);
        end
        chk("no_drop_cnt", drop_cnt, 8'h0);

        // Two-beat packet to unmapped channel 3; beat 2 carries sel=0 which must be ignored.
        d3_valid = 1'b1; d3_sel = 2'd3; d3_data = 8'h55; d3_last = 1'b0;
        #1;
        chk("drop_in_ready", d3_ready, 1'b1);
        edge_wait();
        chk("drop1_err", d3_err, 1'b1);
        chk("drop1_cnt", d3_drop_cnt, 2'd1);
        chk("drop1_ov",  d3_out_valid, 3'h0);
        d3_sel = 2'd0; d3_data = 8'h66; d3_last = 1'b1;
        edge_wait();
        chk("drop2_err", d3_err, 1'b1);
        chk("drop2_cnt", d3_drop_cnt, 2'd2);
        chk("drop2_ov",  d3_out_valid, 3'h0);
        d3_valid = 1'b0;
        edge_wait();
        chk("drop_idle_err", d3_err, 1'b0);
        chk("drop_idle_cnt", d3_drop_cnt, 2'd2);
        d3_valid = 1'b1; d3_sel = 2'd3; d3_last = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            edge_wait();
            chk($sformatf("drop%0d_err", k), d3_err, 1'b1);
            chk($sformatf("drop%0d_cnt", k), d3_drop_cnt, 2'd3);
        end
        d3_valid = 1'b0;
        // A mapped single beat after the drops must still route normally.
        d3_sel = 2'd2; d3_data = 8'h77; d3_valid = 1'b1;
        edge_wait();
        d3_valid = 1'b0;
        chk("d3_route_ov",   d3_out_valid, 3'h4);
        chk("d3_route_data", d3_out_data[23:16], 8'h77);
        chk("d3_route_err",  d3_err, 1'b0);

        // Reset mid-packet: first beat to ch2, then reset, then a single beat to ch0.
        out_ready = 4'hF;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hD1; in_last = 1'b0;
        edge_wait();
        chk("mid_ov", out_valid, 4'h4);
        in_valid = 1'b0;
        rst = 1'b1;
        edge_wait();
        chk("mid_rst_ov",   out_valid, 4'h0);
        chk("mid_rst_od",   out_data, 32'h0);
        chk("mid_rst_d3cnt", d3_drop_cnt, 2'd0);
        rst = 1'b0;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hE0; in_last = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        edge_wait();
        in_valid = 1'b0;
        chk("post_rst_ov",   out_valid, 4'h1);
        chk("post_rst_od",   out_data, 32'h000000E0);
        chk("post_rst_last", out_last, 4'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
